// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-ST pixel packer: bus widths, the frame
// FSM state type and the layout of one output FIFO entry.
package avalon_pkg;

  localparam int PIXEL_W = 24;
  localparam int WORD_W  = 32;
  localparam int EMPTY_W = 2;

  // IDLE: no frame open, PACK: between sop and eop of a frame.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PACK = 1'b1
  } state_t;

  // One packed output word plus its framing sideband, as stored in the FIFO.
  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [WORD_W-1:0]  data;
  } word_t;

  localparam int ENTRY_W = $bits(word_t);

endpackage

// File: rtl/avalon_pixel_packer_if.sv
// Avalon-ST sink (24-bit pixels) and source (32-bit words) signals of the
// packer. The slave modport is the packer's view, master is the environment.
interface avalon_pixel_packer_if;
  import avalon_pkg::*;

  logic               Sink_ready;
  logic               Sink_valid;
  logic [PIXEL_W-1:0] Sink_data;
  logic               Sink_sop;
  logic               Sink_eop;

  logic               Source_ready;
  logic               Source_valid;
  logic [WORD_W-1:0]  Source_data;
  logic               Source_sop;
  logic               Source_eop;
  logic [EMPTY_W-1:0] Source_empty;

  modport slave (
    output Sink_ready,
    input  Sink_valid, Sink_data, Sink_sop, Sink_eop,
    input  Source_ready,
    output Source_valid, Source_data, Source_sop, Source_eop, Source_empty
  );

  modport master (
    input  Sink_ready,
    output Sink_valid, Sink_data, Sink_sop, Sink_eop,
    output Source_ready,
    input  Source_valid, Source_data, Source_sop, Source_eop, Source_empty
  );

endinterface

// File: rtl/avalon_word_fifo.sv
// First-word-fall-through FIFO with up to two writes and one read per cycle.
// The head entry is visible on o_rdata whenever o_valid is high; the output
// reads as zero while the FIFO is empty.
module avalon_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             i_wr0,
  input  logic [WIDTH-1:0] i_wdata0,
  input  logic             i_wr1,
  input  logic [WIDTH-1:0] i_wdata1,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic             o_free_ge2
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW-1:0]    w_wr_ptr1;
  logic             w_pop;

  assign w_wr_ptr1  = r_wr_ptr + AW'(1);
  assign o_valid    = (r_count != '0);
  assign w_pop      = i_rd & o_valid;
  assign o_free_ge2 = (int'(r_count) + 2) <= DEPTH;
  assign o_rdata    = o_valid ? r_mem[r_rd_ptr] : '0;

  // Storage writes; the second write lands in the slot after the first.
  // NOTE: the data array has no reset; occupancy lives in r_count, so stale
  // contents are never observable and the array can map to plain RAM.
  always_ff @(posedge Clk) begin
    if (i_wr0) r_mem[r_wr_ptr] <= i_wdata0;
    if (i_wr1) r_mem[w_wr_ptr1] <= i_wdata1;
  end

  // Pointer and occupancy bookkeeping; push and pop in one cycle net out.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr0 && i_wr1) r_wr_ptr <= r_wr_ptr + AW'(2);
      else if (i_wr0)     r_wr_ptr <= w_wr_ptr1;
      if (w_pop)          r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, i_wr0} + {{AW{1'b0}}, i_wr1}
                         - {{AW{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/avalon_pixel_packer.sv
// Packs a stream of 24-bit pixels into little-endian 32-bit words. Up to
// three residual bytes carry over between pixels; the eop pixel flushes the
// residue as a zero-padded word with Source_empty set. Words queue in a
// small FWFT FIFO towards the downstream DMA.
module avalon_pixel_packer
  import avalon_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  avalon_pixel_packer_if.slave bus,
  output logic                 Err_sync,
  output logic [15:0]          Frame_count
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_phase;
  logic [PIXEL_W-1:0]   r_res;
  logic                 r_first;
  logic                 r_err;
  logic [15:0]          r_frames;

  logic                 w_xfer;
  logic                 w_accept;
  logic                 w_start;
  logic                 w_err_evt;
  logic [1:0]           w_p;
  logic [PIXEL_W-1:0]   w_res;
  logic                 w_first;
  logic [2*PIXEL_W-1:0] w_cat;
  logic [2:0]           w_total;
  logic                 w_main_v;
  logic                 w_has_tail;
  logic [1:0]           w_left_n;
  logic [PIXEL_W-1:0]   w_left;
  word_t                w_word_a;
  word_t                w_word_b;
  word_t                w_wdata0;
  word_t                w_wdata1;
  word_t                w_rdata;
  logic                 w_wr0;
  logic                 w_wr1;
  logic                 w_fifo_valid;
  logic                 w_free_ge2;

  // Room for two words is required because an eop pixel can emit two.
  assign bus.Sink_ready = w_free_ge2 & Reset_n;
  assign w_xfer         = bus.Sink_valid & bus.Sink_ready;

  // Frame state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Frame tracking: decide whether a transferred pixel is packed, dropped or
  // flags a framing error. A sop+eop pixel in IDLE opens and closes at once.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_err_evt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (bus.Sink_sop) begin
            w_accept    = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = bus.Sink_eop ? ST_IDLE : ST_PACK;
          end else begin
            w_err_evt = 1'b1;
          end
        end
      end
      ST_PACK: begin
        if (w_xfer) begin
          w_accept  = 1'b1;
          w_err_evt = bus.Sink_sop;
          if (bus.Sink_eop) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte packing: append the pixel above the residue, emit a full word when
  // at least four bytes are present and, on eop, flush the rest padded.
  always_comb begin
    w_p      = w_start ? 2'd0 : r_phase;
    w_res    = w_start ? '0 : r_res;
    w_first  = w_start | r_first;
    w_cat    = ({{PIXEL_W{1'b0}}, bus.Sink_data} << {w_p, 3'b000})
             | {{PIXEL_W{1'b0}}, w_res};
    w_total  = {1'b0, w_p} + 3'd3;
    w_main_v = w_total[2];
    if (w_main_v) begin
      w_left_n = w_total[1:0];
      w_left   = PIXEL_W'(w_cat[2*PIXEL_W-1:WORD_W]);
    end else begin
      w_left_n = 2'd3;
      w_left   = w_cat[PIXEL_W-1:0];
    end
    w_has_tail = bus.Sink_eop && (w_left_n != 2'd0);

    w_word_a = '{sop:   w_first,
                 eop:   bus.Sink_eop && (w_left_n == 2'd0),
                 empty: '0,
                 data:  w_cat[WORD_W-1:0]};
    w_word_b = '{sop:   w_first & ~w_main_v,
                 eop:   1'b1,
                 empty: EMPTY_W'(3'd4 - {1'b0, w_left_n}),
                 data:  WORD_W'(w_left)};

    w_wr0    = w_accept & (w_main_v | w_has_tail);
    w_wr1    = w_accept & w_main_v & w_has_tail;
    w_wdata0 = w_main_v ? w_word_a : w_word_b;
    w_wdata1 = w_word_b;
  end

  // Residue, sop-pending flag, sticky error and frame counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_phase  <= 2'd0;
      r_res    <= '0;
      r_first  <= 1'b0;
      r_err    <= 1'b0;
      r_frames <= '0;
    end else begin
      if (w_err_evt) r_err <= 1'b1;
      if (w_accept) begin
        if (bus.Sink_eop) begin
          r_phase  <= 2'd0;
          r_res    <= '0;
          r_first  <= 1'b0;
          r_frames <= r_frames + 16'd1;
        end else begin
          r_phase  <= w_left_n;
          r_res    <= w_left;
          r_first  <= w_first & ~w_wr0;
        end
      end
    end
  end

  avalon_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .i_wr0      (w_wr0),
    .i_wdata0   (w_wdata0),
    .i_wr1      (w_wr1),
    .i_wdata1   (w_wdata1),
    .i_rd       (bus.Source_ready),
    .o_rdata    (w_rdata),
    .o_valid    (w_fifo_valid),
    .o_free_ge2 (w_free_ge2)
  );

  assign bus.Source_valid = w_fifo_valid;
  assign bus.Source_data  = w_rdata.data;
  assign bus.Source_sop   = w_rdata.sop;
  assign bus.Source_eop   = w_rdata.eop;
  assign bus.Source_empty = w_rdata.empty;
  assign Err_sync         = r_err;
  assign Frame_count      = r_frames;

endmodule
